// File: rtl/sl3_tx_packet_buffer.sv
// rtl/sl3_tx_packet_buffer.sv - store-and-forward packet buffer feeding one SerialLite III TX lane
//
// Packets are held until their last word is stored, then streamed
// back-to-back so an upstream stall cannot starve the lane mid-packet.
// A packet larger than the buffer is forwarded cut-through and flagged
// in oversize_err.
//
// Optional feature macro: SL3_TX_STATS_EN (packet and stall statistics).
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   in_data/in_last/in_valid   word from the router; in_ready = space available
//   out_data/out_last/out_valid word to the lane; out_full throttles output
//   pkt_count                  complete packets held, until their last word leaves
//   occupancy                  words held, output stage included
//   oversize_err               sticky oversize-packet flag
//   stat_pkts_sent             packets delivered (0 without SL3_TX_STATS_EN)
//   stat_stall_cycles          cycles with out_valid && out_full (0 without SL3_TX_STATS_EN)
module sl3_tx_packet_buffer #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_full,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     oversize_err,
    output logic [31:0]              stat_pkts_sent,
    output logic [31:0]              stat_stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_CUT
    } state_t;

    // Each entry carries {last, data}.
    logic [DATA_W:0]     r_mem [DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [AW:0]         r_pkt_count;
    state_t              r_state;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_oversize;

    logic [AW:0]         w_occupancy;
    logic                w_in_ready;
    logic                w_wr_en;
    logic                w_out_xfer;
    logic                w_in_last_xfer;
    logic                w_out_last_xfer;
    logic [AW:0]         w_rd_ptr_nxt;
    logic                w_bypass;
    logic                w_avail;
    logic [DATA_W:0]     w_load_word;
    logic [AW:0]         w_pkt_nxt;

    // The presented word stays in RAM until it transfers, so the pointer
    // difference already includes the output stage.
    assign w_occupancy     = r_wr_ptr - r_rd_ptr;
    assign w_in_ready      = (w_occupancy != FULL_CNT);
    assign w_wr_en         = in_valid && w_in_ready;
    assign w_out_xfer      = r_out_valid && !out_full;
    assign w_in_last_xfer  = w_wr_en && in_last;
    assign w_out_last_xfer = w_out_xfer && r_out_last;
    assign w_rd_ptr_nxt    = w_out_xfer ? (r_rd_ptr + ONE) : r_rd_ptr;

    // The next word to present may be the one being written this very
    // cycle (back-to-back 1-word packets, cut-through); forward it directly.
    assign w_bypass    = (w_rd_ptr_nxt == r_wr_ptr);
    assign w_avail     = !w_bypass || w_wr_en;
    assign w_load_word = w_bypass ? {in_last, in_data} : r_mem[w_rd_ptr_nxt[AW-1:0]];

    always_comb begin
        w_pkt_nxt = r_pkt_count;
        if (w_in_last_xfer && !w_out_last_xfer) begin
            w_pkt_nxt = r_pkt_count + ONE;
        end else if (!w_in_last_xfer && w_out_last_xfer) begin
            w_pkt_nxt = r_pkt_count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_count <= '0;
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_oversize  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_pkt_count <= w_pkt_nxt;

            case (r_state)
                ST_IDLE: begin
                    if (r_pkt_count != '0) begin
                        r_state                  <= ST_SEND;
                        r_out_valid              <= 1'b1;
                        {r_out_last, r_out_data} <= w_load_word;
                    end else if (w_occupancy == FULL_CNT) begin
                        // Buffer full with no complete packet: the packet can
                        // never commit, so release it cut-through.
                        r_state                  <= ST_CUT;
                        r_oversize               <= 1'b1;
                        r_out_valid              <= 1'b1;
                        {r_out_last, r_out_data} <= w_load_word;
                    end
                end
                ST_SEND: begin
                    if (w_out_xfer) begin
                        if (r_out_last && (w_pkt_nxt == '0)) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end else begin
                            {r_out_last, r_out_data} <= w_load_word;
                        end
                    end
                end
                ST_CUT: begin
                    if (w_out_last_xfer) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else if (w_out_xfer || !r_out_valid) begin
                        r_out_valid <= w_avail;
                        if (w_avail) begin
                            {r_out_last, r_out_data} <= w_load_word;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign out_valid    = r_out_valid;
    assign pkt_count    = r_pkt_count;
    assign occupancy    = w_occupancy;
    assign oversize_err = r_oversize;

`ifdef SL3_TX_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_pkts  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_out_last_xfer) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if (r_out_valid && out_full) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_pkts_sent    = r_stat_pkts;
    assign stat_stall_cycles = r_stat_stall;
`else
    assign stat_pkts_sent    = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sl3_tx_packet_buffer.sv
// tb/tb_sl3_tx_packet_buffer.sv - directed self-checking bench for sl3_tx_packet_buffer
module tb_sl3_tx_packet_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_full;
    logic [3:0]    pkt_count;
    logic [3:0]    occupancy;
    logic          oversize_err;
    logic [31:0]   stat_pkts_sent;
    logic [31:0]   stat_stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    sl3_tx_packet_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_valid         (out_valid),
        .out_full          (out_full),
        .pkt_count         (pkt_count),
        .occupancy         (occupancy),
        .oversize_err      (oversize_err),
        .stat_pkts_sent    (stat_pkts_sent),
        .stat_stall_cycles (stat_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic recv(input string tag, input logic [DW-1:0] d, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
        cyc();
    endtask

    // Streams n words (packets of plen words) with out_full low and checks
    // every delivered word against base+index; bounded to 200 cycles.
    task automatic run_stream(input string tag, input int n, input int plen,
                              input logic [DW-1:0] base, input bit steady, input bit cut);
        int in_i = 0;
        int out_i = 0;
        int cyc_n = 0;
        int first = -1;
        int lastc = -1;
        bit acc;
        bit ox;
        bit seen = 1'b0;
        in_valid = 1'b1;
        in_data  = base;
        in_last  = (plen == 1);
        while (out_i < n && cyc_n < 200) begin
            acc = in_valid && in_ready;
            ox  = out_valid && !out_full;
            if (cut && !seen && out_valid) begin
                seen = 1'b1;
                chk({tag, "_cut_occ"}, 32'(occupancy), DEPTH);
                chk({tag, "_cut_err"}, 32'(oversize_err), 32'd1);
            end
            if (ox) begin
                chk({tag, "_data"}, 32'(out_data), 32'(DW'(base + out_i)));
                chk({tag, "_last"}, 32'(out_last), 32'((out_i % plen) == plen - 1));
                if (steady && acc) chk({tag, "_pkt_const"}, 32'(pkt_count), 32'd2);
                if (first < 0) first = cyc_n;
                lastc = cyc_n;
                out_i++;
            end
            cyc();
            cyc_n++;
            if (acc) in_i++;
            in_valid = (in_i < n);
            in_data  = DW'(base + in_i);
            in_last  = ((in_i % plen) == plen - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_words_out"}, out_i, n);
        if (steady) chk({tag, "_no_bubble"}, lastc - first, n - 1);
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        in_data  = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
        out_full = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_oversize",  32'(oversize_err), 32'd0);
        chk("rst_stat_pkts", stat_pkts_sent, 32'd0);
        chk("rst_stat_stall", stat_stall_cycles, 32'd0);

        // 3-word packet: latency and ordering
        in_valid = 1'b1; in_data = 16'hA000; in_last = 1'b0; cyc();
        in_data = 16'hA001; cyc();
        in_data = 16'hA002; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("a_pkt_count_1", 32'(pkt_count), 32'd1);
        chk("a_not_yet_valid", 32'(out_valid), 32'd0);
        cyc();
        recv("a0", 16'hA000, 1'b0);
        recv("a1", 16'hA001, 1'b0);
        chk("a2_pkt_count", 32'(pkt_count), 32'd1);
        recv("a2", 16'hA002, 1'b1);
        chk("a_end_valid", 32'(out_valid), 32'd0);
        chk("a_end_pkt", 32'(pkt_count), 32'd0);
        chk("a_end_occ", 32'(occupancy), 32'd0);

        // Partial packet is held until its last word arrives
        in_valid = 1'b1; in_data = 16'hB000; cyc();
        in_data = 16'hB001; cyc();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (out_valid) bad++;
        end
        chk("b_hold_valid", bad, 0);
        chk("b_hold_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b1; in_data = 16'hB002; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        cyc();
        recv("b0", 16'hB000, 1'b0);
        recv("b1", 16'hB001, 1'b0);
        recv("b2", 16'hB002, 1'b1);
        chk("b_end_valid", 32'(out_valid), 32'd0);

        // Fill with eight 1-word packets while the lane is full
        out_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = DW'(16'hC000 + i); in_last = 1'b1; cyc();
        end
        in_valid = 1'b0;
        chk("c_in_ready_0", 32'(in_ready), 32'd0);
        chk("c_pkt_count_8", 32'(pkt_count), 32'd8);
        chk("c_occ_8", 32'(occupancy), 32'd8);
        in_valid = 1'b1; in_data = 16'hBAD0; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("c_reject_occ", 32'(occupancy), 32'd8);
        out_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            recv("c", DW'(16'hC000 + i), 1'b1);
        end
        chk("c_end_valid", 32'(out_valid), 32'd0);
        chk("c_end_pkt", 32'(pkt_count), 32'd0);
        chk("c_in_ready_1", 32'(in_ready), 32'd1);
`ifdef SL3_TX_STATS_EN
        chk("c_stat_stall_ge1", 32'(stat_stall_cycles >= 32'd1), 32'd1);
        chk("c_stat_pkts", stat_pkts_sent, 32'd10);
`else
        chk("c_stat_stall_off", stat_stall_cycles, 32'd0);
        chk("c_stat_pkts_off", stat_pkts_sent, 32'd0);
`endif

        // Oversize 10-word packet goes cut-through
        run_stream("d", 10, 10, 16'h0D00, 1'b0, 1'b1);
        cyc();
        chk("d_err_sticky", 32'(oversize_err), 32'd1);
        chk("d_end_pkt", 32'(pkt_count), 32'd0);
        chk("d_end_occ", 32'(occupancy), 32'd0);
        chk("d_end_valid", 32'(out_valid), 32'd0);

        // Steady stream of 1-word packets
        run_stream("e", 12, 1, 16'h0E00, 1'b1, 1'b0);
        cyc();
        chk("e_end_pkt", 32'(pkt_count), 32'd0);

        // Reset mid-packet with committed and partial data resident
        out_full = 1'b1;
        in_valid = 1'b1; in_data = 16'hF000; in_last = 1'b1; cyc();
        in_data = 16'hF001; in_last = 1'b0; cyc();
        in_data = 16'hF002; cyc();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("r_out_valid", 32'(out_valid), 32'd0);
        chk("r_occ", 32'(occupancy), 32'd0);
        chk("r_pkt", 32'(pkt_count), 32'd0);
        chk("r_oversize", 32'(oversize_err), 32'd0);
        chk("r_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst = 1'b0;
        out_full = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (out_valid) bad++;
        end
        chk("r_no_emit", bad, 0);
        run_stream("g", 3, 3, 16'h0A50, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
